// File: rtl/rf_pkg.sv
// Shared register-file writeback types and constants.
package rf_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;
  localparam logic [RF_AW-1:0] RF_ZERO = 5'd0;

  // One queued register-file write.
  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small per-source writeback FIFO. Besides the head it exposes the valid bit
// and address of every slot so the top can build the pending-write mask.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_req_t                     push_req,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output wb_req_t                     head,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][RF_AW-1:0] ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t                   mem [DEPTH];
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [CW-1:0]             count;
  logic [DEPTH-1:0][PW-1:0]  ent_off;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    ent_off   = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_off[i]   = PW'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, ent_off[i]} < count);
      ent_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the RF write port between the ALU writeback
// (src0) and the load / multi-cycle unit (src1). Also produces the pending
// write mask for decode hazards and flags overlapping writes to one register.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [AW-1:0]   s0_addr,
  input  logic [DW-1:0]   s0_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [AW-1:0]   s1_addr,
  input  logic [DW-1:0]   s1_data,
  input  logic            rf_hold,
  output logic            rf_wen,
  output logic [AW-1:0]   rfWriteAddr,
  output logic [DW-1:0]   rfWriteData,
  output logic [2**AW-1:0] pending_mask,
  output logic            wr_conflict
);

  logic                        full0, empty0, full1, empty1;
  wb_req_t                     head0, head1;
  logic [DEPTH-1:0]            ent_valid0, ent_valid1;
  logic [DEPTH-1:0][RF_AW-1:0] ent_addr0, ent_addr1;
  logic                        acc0, acc1, push0, push1;
  logic                        grant0, grant1;
  logic                        rr_ptr;
  logic                        conflict_nxt;
  wb_req_t                     req0, req1;

  // Ready reflects occupancy only; a same-cycle pop does not free a full FIFO.
  assign s0_ready = !rst && !full0;
  assign s1_ready = !rst && !full1;
  assign acc0     = s0_valid && s0_ready;
  assign acc1     = s1_valid && s1_ready;
  // Writes to the zero register are swallowed at the door.
  assign push0    = acc0 && (s0_addr != RF_ZERO);
  assign push1    = acc1 && (s1_addr != RF_ZERO);
  assign req0     = '{addr: s0_addr, data: s0_data};
  assign req1     = '{addr: s1_addr, data: s1_data};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_req  (req0),
    .pop       (grant0),
    .full      (full0),
    .empty     (empty0),
    .head      (head0),
    .ent_valid (ent_valid0),
    .ent_addr  (ent_addr0)
  );

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_req  (req1),
    .pop       (grant1),
    .full      (full1),
    .empty     (empty1),
    .head      (head1),
    .ent_valid (ent_valid1),
    .ent_addr  (ent_addr1)
  );

  // Grant one head per cycle; rr_ptr breaks ties when both heads are valid.
  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    rf_wen      = 1'b0;
    rfWriteAddr = '0;
    rfWriteData = '0;
    if (!rf_hold) begin
      if (!empty0 && !empty1) begin
        grant0 = (rr_ptr == 1'b0);
        grant1 = (rr_ptr == 1'b1);
      end else begin
        grant0 = !empty0;
        grant1 = !empty1;
      end
    end
    if (grant0) begin
      rf_wen      = 1'b1;
      rfWriteAddr = head0.addr;
      rfWriteData = head0.data;
    end else if (grant1) begin
      rf_wen      = 1'b1;
      rfWriteAddr = head1.addr;
      rfWriteData = head1.data;
    end
  end

  // After a grant, priority passes to the other source.
  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (grant0) rr_ptr <= 1'b1;
    else if (grant1) rr_ptr <= 1'b0;
  end

  // Pending mask: one bit per register targeted by any live slot.
  always_comb begin
    pending_mask = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_valid0[e]) pending_mask[ent_addr0[e]] = 1'b1;
      if (ent_valid1[e]) pending_mask[ent_addr1[e]] = 1'b1;
    end
  end

  // Overlap detection against writes already queued or arriving together.
  always_comb begin
    conflict_nxt = (push0 && pending_mask[s0_addr]) ||
                   (push1 && pending_mask[s1_addr]) ||
                   (push0 && push1 && (s0_addr == s1_addr));
  end

  // Conflict is reported as a registered single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= conflict_nxt;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_addr, s1_addr;
  logic [31:0] s0_data, s1_data;
  logic        rf_hold;
  logic        rf_wen;
  logic [4:0]  rfWriteAddr;
  logic [31:0] rfWriteData;
  logic [31:0] pending_mask;
  logic        wr_conflict;

  int checks = 0;
  int errors = 0;

  // Reference model state
  wb_req_t q0[$];
  wb_req_t q1[$];
  int      rr_pref = 0;
  bit      cf_q    = 1'b0;

  rf_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s0_addr      (s0_addr),
    .s0_data      (s0_data),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .s1_addr      (s1_addr),
    .s1_data      (s1_data),
    .rf_hold      (rf_hold),
    .rf_wen       (rf_wen),
    .rfWriteAddr  (rfWriteAddr),
    .rfWriteData  (rfWriteData),
    .pending_mask (pending_mask),
    .wr_conflict  (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_mask();
    logic [31:0] m;
    m = '0;
    foreach (q0[i]) m[q0[i].addr] = 1'b1;
    foreach (q1[i]) m[q1[i].addr] = 1'b1;
    return m;
  endfunction

  task automatic drive_idle();
    rst      = 1'b0;
    rf_hold  = 1'b0;
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
  endtask

  // One clock cycle: drive at the falling edge, check, let the edge happen,
  // advance the model, and come back to the next falling edge with idle inputs.
  task automatic step(input bit r, input bit h,
                      input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bit          er0, er1, ewen, ecf, acc0, acc1;
    int          g;
    logic [4:0]  ea;
    logic [31:0] ed, m;
    wb_req_t     w;
    rst = r; rf_hold = h;
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    #1;
    er0 = !r && (q0.size() < DEPTH);
    er1 = !r && (q1.size() < DEPTH);
    g = -1;
    if (!h) begin
      if (q0.size() > 0 && q1.size() > 0) g = rr_pref;
      else if (q0.size() > 0)             g = 0;
      else if (q1.size() > 0)             g = 1;
    end
    ewen = (g >= 0);
    ea = '0; ed = '0;
    if (g == 0) begin ea = q0[0].addr; ed = q0[0].data; end
    if (g == 1) begin ea = q1[0].addr; ed = q1[0].data; end
    m = mdl_mask();
    chk("s0_ready",     32'(s0_ready),     32'(er0));
    chk("s1_ready",     32'(s1_ready),     32'(er1));
    chk("rf_wen",       32'(rf_wen),       32'(ewen));
    chk("rfWriteAddr",  32'(rfWriteAddr),  32'(ea));
    chk("rfWriteData",  rfWriteData,       ed);
    chk("pending_mask", pending_mask,      m);
    chk("wr_conflict",  32'(wr_conflict),  32'(cf_q));
    @(posedge clk);
    if (r) begin
      q0.delete(); q1.delete();
      rr_pref = 0; cf_q = 1'b0;
    end else begin
      acc0 = v0 && er0;
      acc1 = v1 && er1;
      ecf = (acc0 && a0 != 0 && m[a0]) || (acc1 && a1 != 0 && m[a1]) ||
            (acc0 && acc1 && a0 != 0 && a0 == a1);
      cf_q = ecf;
      if (g == 0) begin void'(q0.pop_front()); rr_pref = 1; end
      if (g == 1) begin void'(q1.pop_front()); rr_pref = 0; end
      if (acc0 && a0 != 0) begin w.addr = a0; w.data = d0; q0.push_back(w); end
      if (acc1 && a1 != 0) begin w.addr = a1; w.data = d1; q1.push_back(w); end
    end
    @(negedge clk);
    drive_idle();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 5'd4, 32'h1, 1, 5'd4, 32'h2);

    // Single write from src0, then drain
    step(0, 0, 1, 5'd3, 32'h11, 0, 0, 0);
    chk("t1_wen",  32'(rf_wen),      32'd1);
    chk("t1_addr", 32'(rfWriteAddr), 32'd3);
    chk("t1_data", rfWriteData,      32'h11);
    chk("t1_mask", pending_mask,     32'h8);
    idle(2);
    chk("t1_wen_after",  32'(rf_wen), 32'd0);
    chk("t1_mask_after", pending_mask, 32'h0);

    // Same-edge pair with rr at 0, twice
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
    chk("t2_first_addr", 32'(rfWriteAddr), 32'd5);
    idle(1);
    chk("t2_second_addr", 32'(rfWriteAddr), 32'd6);
    idle(1);
    step(0, 0, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
    chk("t2_repeat_addr", 32'(rfWriteAddr), 32'd5);
    idle(3);

    // Hold fills both FIFOs, then release drains alternately
    step(0, 1, 1, 5'd1, 32'h101, 1, 5'd2, 32'h202);
    step(0, 1, 1, 5'd4, 32'h104, 1, 5'd8, 32'h208);
    step(0, 1, 1, 5'd10, 32'h1, 1, 5'd11, 32'h2);
    rf_hold = 1'b1; #1;
    chk("t3_ready0", 32'(s0_ready), 32'd0);
    chk("t3_ready1", 32'(s1_ready), 32'd0);
    chk("t3_mask",   pending_mask,  32'h116);
    chk("t3_wen",    32'(rf_wen),   32'd0);
    idle(5);

    // Zero-register write is swallowed
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'hFF);
    chk("t4_mask", pending_mask, 32'h0);
    chk("t4_wen",  32'(rf_wen),  32'd0);
    idle(1);

    // Conflicts: queued vs new, then same-edge pair
    step(0, 1, 0, 0, 0, 1, 5'd7, 32'h77);
    step(0, 1, 1, 5'd7, 32'h1, 0, 0, 0);
    chk("t5_pulse", 32'(wr_conflict), 32'd1);
    idle(1);
    chk("t5_pulse_end", 32'(wr_conflict), 32'd0);
    idle(3);
    step(0, 0, 1, 5'd9, 32'h9A, 1, 5'd9, 32'h9B);
    chk("t5_pair_pulse", 32'(wr_conflict), 32'd1);
    idle(4);

    // Reset in the middle of a drain
    step(0, 1, 1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    step(0, 1, 1, 5'd14, 32'hE0, 1, 5'd15, 32'hF0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 25),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
